// File: rtl/cpc_bus_timing.sv
// Bus-phase counter, Z80 wait-state generator, CRTC/PSG enable slots and round-robin DMA slot arbiter.
// Latency: phase/io_cnt registered, wait_n/crtc_ce/psg_ce combinational; dma_ack/dma_slot/dma_ch 1 clk after the slot.
// Backpressure: none; requests are level-held until granted. Define CPC_DMA_EN to build the DMA arbiter.
module cpc_bus_timing #(
    parameter int PHASES    = 4,
    parameter int IO_EXTRA  = 0,
    parameter int CHANNELS  = 3,
    parameter int DMA_PHASE = 2
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          ce_4p,
    input  logic                                          ce_4n,
    input  logic                                          mreq_n,
    input  logic                                          iorq_n,
    input  logic                                          m1_n,
    input  logic                                          rfsh_n,
    input  logic                                          no_wait,
    output logic [$clog2(PHASES)-1:0]                     phase,
    output logic                                          wait_n,
    output logic                                          crtc_ce,
    output logic                                          psg_ce,
    input  logic [CHANNELS-1:0]                           dma_req,
    output logic [CHANNELS-1:0]                           dma_ack,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] dma_ch,
    output logic                                          dma_slot
);

    localparam int PW = $clog2(PHASES);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);
    localparam logic [PW-1:0] PH_DMA  = PW'(DMA_PHASE);
    localparam logic [2:0]    IO_SAT  = 3'(IO_EXTRA);

    logic       io_cycle;
    logic [2:0] io_cnt;
    logic       phase_zero;
    logic       phase_last;

    assign phase_zero = (phase == '0);
    assign phase_last = (phase == PH_LAST);

    // INTack (iorq_n & m1_n both low) is treated like a memory cycle.
    assign io_cycle = ~iorq_n & m1_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
        end else if (ce_4p) begin
            phase <= phase_last ? '0 : phase + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_cnt <= '0;
        end else if (iorq_n) begin
            io_cnt <= '0;
        end else if (io_cycle && ce_4p && phase_last && (io_cnt != IO_SAT)) begin
            io_cnt <= io_cnt + 3'd1;
        end
    end

    assign wait_n  = no_wait
                   | (mreq_n & iorq_n)
                   | (phase_zero & (~io_cycle | (io_cnt == IO_SAT)));

    assign crtc_ce = ce_4p & phase_zero;
    assign psg_ce  = ce_4n & phase_zero;

`ifdef CPC_DMA_EN
    logic          slot_hit;
    logic [CW-1:0] rr;
    logic          grant_vld;
    logic [CW-1:0] grant_idx;
    logic [CW:0]   cand;
    logic [CW-1:0] rr_next;

    // A slot is a bus-idle or refresh cycle at the configured phase.
    assign slot_hit = ce_4p & (phase == PH_DMA) & (mreq_n | ~rfsh_n);

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr;
        cand      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = {1'b0, rr} + (CW+1)'(k);
            if (cand >= (CW+1)'(CHANNELS)) begin
                cand = cand - (CW+1)'(CHANNELS);
            end
            if (!grant_vld && dma_req[cand[CW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[CW-1:0];
            end
        end
    end

    assign rr_next = (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr       <= '0;
            dma_ack  <= '0;
            dma_slot <= 1'b0;
            dma_ch   <= '0;
        end else begin
            dma_ack  <= '0;
            dma_slot <= 1'b0;
            if (slot_hit && grant_vld) begin
                dma_ack  <= CHANNELS'(1) << grant_idx;
                dma_slot <= 1'b1;
                dma_ch   <= grant_idx;
                rr       <= rr_next;
            end
        end
    end
`else
    logic dma_unused;
    assign dma_unused = ^{dma_req, rfsh_n};

    assign dma_ack  = '0;
    assign dma_slot = 1'b0;
    assign dma_ch   = '0;
`endif

endmodule
